// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: round-robin arbiter and phase sequencer sharing one memory port between core and external master
module mem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int READ_LAT = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic              core_ready,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_ready,
  output logic [DATA_W-1:0] rdata,
  output logic              owner,
  output logic              busy,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state;
  logic we;
  logic [2:0] cnt;
  logic grant_ext, grant_we;
  // on a tie the master that did not own the last transaction wins
  always_comb begin
    grant_ext = ext_req & (~core_req | ~owner);
    grant_we = grant_ext ? ext_we : core_we;
  end
  assign busy = state != IDLE;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state <= IDLE;
      we <= 1'b0;
      cnt <= 3'd0;
      owner <= 1'b1;
      mem_we <= 1'b0;
      mem_addr <= '0;
      mem_wdata <= '0;
      rdata <= '0;
      core_ready <= 1'b0;
      ext_ready <= 1'b0;
    end else begin
      case (state)
        IDLE: if (core_req | ext_req) begin
          state <= ACCESS;
          owner <= grant_ext;
          mem_addr <= grant_ext ? ext_addr : core_addr;
          mem_wdata <= grant_ext ? ext_wdata : core_wdata;
          we <= grant_we;
          mem_we <= grant_we;
          cnt <= grant_we ? 3'd0 : 3'(READ_LAT - 1);
        end
        ACCESS: begin
          mem_we <= 1'b0;
          if (we || cnt == 3'd0) begin
            state <= RESP;
            if (!we) rdata <= mem_rdata;
            core_ready <= ~owner;
            ext_ready <= owner;
          end else cnt <= cnt - 3'd1;
        end
        default: begin
          state <= IDLE;
          core_ready <= 1'b0;
          ext_ready <= 1'b0;
        end
      endcase
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: randomized masters checked against a cycle-timed transaction model, plus directed literal checks
module tb_mem_port_arbiter;
  localparam int LAT = 2;
  logic clk = 0, rst = 0, rst4 = 0;
  always #5 clk = ~clk;
  logic core_req = 0, core_we = 0, ext_req = 0, ext_we = 0, r4_req = 0;
  logic [31:0] core_addr = 0, core_wdata = 0, ext_addr = 0, ext_wdata = 0;
  logic [31:0] mem_rdata;
  logic core_ready, ext_ready, owner, busy, mem_we;
  logic [31:0] rdata, mem_addr, mem_wdata;
  logic c4_ready, e4_ready, owner4, busy4, we4;
  logic [31:0] rdata4, addr4, wdata4;
  logic [31:0] env_mem [256];
  logic [31:0] mdl_mem [256];
  int n_chk = 0, n_fail = 0, c = 0;
  bit chk_en = 0;
  int gr_t = -100, occ = 0, free_t = 0;
  bit g_owner = 1, g_we = 0;
  logic [31:0] g_addr = 0, g_wdata = 0, g_rdata = 0;
  bit exp_busy = 0, exp_we = 0, exp_cr = 0, exp_er = 0, exp_owner = 1;
  logic [31:0] exp_addr = 0, exp_wdata = 0, exp_rdata = 0;

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata), .core_ready(core_ready),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata), .ext_ready(ext_ready),
    .rdata(rdata), .owner(owner), .busy(busy),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata)
  );

  mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .READ_LAT(4)) dut4 (
    .clk(clk), .rst(rst4),
    .core_req(r4_req), .core_we(1'b0), .core_addr(32'h80), .core_wdata(32'h0), .core_ready(c4_ready),
    .ext_req(1'b0), .ext_we(1'b0), .ext_addr(32'h0), .ext_wdata(32'h0), .ext_ready(e4_ready),
    .rdata(rdata4), .owner(owner4), .busy(busy4),
    .mem_addr(addr4), .mem_wdata(wdata4), .mem_we(we4), .mem_rdata(32'hCAFEF00D)
  );

  // synchronous BRAM: one registered read stage gives READ_LAT = 2
  always @(posedge clk) begin
    if (mem_we) env_mem[mem_addr[9:2]] <= mem_wdata;
    mem_rdata <= env_mem[mem_addr[9:2]];
  end

  task automatic chk(string n, logic [31:0] a, logic [31:0] e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at cycle %0d", n, a, e, c);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("busy", 32'(busy), 32'(exp_busy));
    chk("mem_we", 32'(mem_we), 32'(exp_we));
    chk("core_ready", 32'(core_ready), 32'(exp_cr));
    chk("ext_ready", 32'(ext_ready), 32'(exp_er));
    chk("owner", 32'(owner), 32'(exp_owner));
    chk("mem_addr", mem_addr, exp_addr);
    chk("mem_wdata", mem_wdata, exp_wdata);
    chk("rdata", rdata, exp_rdata);
  end

  // a transaction granted in IDLE cycle gr_t occupies gr_t .. gr_t+occ-1
  task automatic events();
    exp_busy = c > gr_t && c < gr_t + occ;
    exp_we = g_we && c == gr_t + 1;
    exp_cr = c == gr_t + occ - 1 && !g_owner;
    exp_er = c == gr_t + occ - 1 && g_owner;
    if (c == gr_t + 1) begin
      exp_owner = g_owner;
      exp_addr = g_addr;
      exp_wdata = g_wdata;
    end
    if (c == gr_t + occ - 1 && !g_we) exp_rdata = g_rdata;
  endtask

  task automatic decide();
    bit e;
    if (c >= free_t && (core_req || ext_req)) begin
      e = ext_req && (!core_req || !g_owner);
      g_owner = e;
      g_we = e ? ext_we : core_we;
      g_addr = e ? ext_addr : core_addr;
      g_wdata = e ? ext_wdata : core_wdata;
      occ = g_we ? 3 : LAT + 2;
      gr_t = c;
      free_t = c + occ;
      if (g_we) mdl_mem[g_addr[9:2]] = g_wdata;
      else g_rdata = mdl_mem[g_addr[9:2]];
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    c++;
    events();
  endtask

  task automatic new_txn(int m, bit rnd_we);
    logic [31:0] a;
    logic w;
    a = $urandom;
    a[9:2] = 8'($urandom_range(0, 7));
    w = rnd_we ? 1'($urandom_range(0, 1)) : 1'b1;
    if (m == 1) begin
      ext_req = 1; ext_we = w; ext_addr = a; ext_wdata = $urandom;
    end else begin
      core_req = 1; core_we = w; core_addr = a; core_wdata = $urandom;
    end
  endtask

  task automatic scramble(int m);
    if (m == 1) begin
      ext_we = 1'($urandom_range(0, 1)); ext_addr = $urandom; ext_wdata = $urandom;
    end else begin
      core_we = 1'($urandom_range(0, 1)); core_addr = $urandom; core_wdata = $urandom;
    end
  endtask

  function automatic bit done(int m);
    return c == gr_t + occ && g_owner == 1'(m);
  endfunction

  initial begin
    for (int i = 0; i < 256; i++) begin
      env_mem[i] = $urandom;
      mdl_mem[i] = env_mem[i];
    end
    env_mem[16] = 32'hDEADBEEF;
    mdl_mem[16] = 32'hDEADBEEF;
    core_req = 1; core_we = 0; core_addr = 32'h40; core_wdata = 32'h0;
    ext_req = 1; ext_we = 1; ext_addr = 32'h100; ext_wdata = 32'h12345678;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_mem_we", 32'(mem_we), 0);
    chk("rst_core_ready", 32'(core_ready), 0);
    chk("rst_ext_ready", 32'(ext_ready), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_owner", 32'(owner), 1);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", mem_addr, 0);
    @(posedge clk);
    #1;
    rst = 1;
    c = 0;
    events();
    chk_en = 1;
    decide();
    step();
    chk("rd_addr_c1", mem_addr, 32'h40);
    chk("rd_owner_core", 32'(owner), 0);
    core_addr = 32'h44;
    decide();
    step();
    chk("rd_addr_held", mem_addr, 32'h40);
    decide();
    step();
    chk("rd_core_ready", 32'(core_ready), 1);
    chk("rd_ext_ready", 32'(ext_ready), 0);
    chk("rd_data", rdata, 32'hDEADBEEF);
    decide();
    step();
    chk("rd_ready_once", 32'(core_ready), 0);
    core_req = 0;
    decide();
    step();
    chk("wr_mem_we", 32'(mem_we), 1);
    chk("wr_addr", mem_addr, 32'h100);
    chk("wr_data", mem_wdata, 32'h12345678);
    decide();
    step();
    chk("wr_ext_ready", 32'(ext_ready), 1);
    chk("wr_we_once", 32'(mem_we), 0);
    chk("wr_rdata_kept", rdata, 32'hDEADBEEF);
    decide();
    step();
    new_txn(0, 0);
    new_txn(1, 0);
    decide();
    for (int k = 0; k < 12; k++) begin
      step();
      if (k % 3 == 0) chk("rr_owner", 32'(owner), 32'((k / 3) % 2));
      if (k % 3 == 1) begin
        chk("rr_core_ready", 32'(core_ready), 32'((k / 3) % 2 == 0));
        chk("rr_ext_ready", 32'(ext_ready), 32'((k / 3) % 2 == 1));
      end
      for (int m = 0; m < 2; m++) if (done(m)) new_txn(m, 0);
      decide();
    end
    repeat (3000) begin
      step();
      for (int m = 0; m < 2; m++) begin
        if (done(m)) begin
          if ($urandom_range(0, 1) == 1) new_txn(m, 1);
          else if (m == 1) ext_req = 0;
          else core_req = 0;
        end else if (c > gr_t && c < gr_t + occ && g_owner == 1'(m)) scramble(m);
        else if (!(m == 1 ? ext_req : core_req) && $urandom_range(0, 2) == 0) new_txn(m, 1);
      end
      decide();
    end
    chk_en = 0;
    core_req = 0;
    ext_req = 0;
    @(posedge clk);
    #1;
    rst4 = 1;
    r4_req = 1;
    for (int d = 1; d <= 10; d++) begin
      @(posedge clk);
      #1;
      if (d <= 5) chk("l4_busy", 32'(busy4), 1);
      if (d == 1) chk("l4_addr", addr4, 32'h80);
      chk("l4_core_ready", 32'(c4_ready), 32'(d == 5));
      chk("l4_ext_ready", 32'(e4_ready), 0);
      if (d == 5) chk("l4_rdata", rdata4, 32'hCAFEF00D);
      if (d == 6) begin
        chk("l4_idle", 32'(busy4), 0);
        r4_req = 0;
      end
      if (d == 8) r4_req = 1;
      if (d == 10) begin
        rst4 = 0;
        #1;
        chk("l4_rst_busy", 32'(busy4), 0);
        chk("l4_rst_rdata", rdata4, 0);
        chk("l4_rst_we", 32'(we4), 0);
        chk("l4_rst_owner", 32'(owner4), 1);
        chk("l4_rst_addr", addr4, 0);
        r4_req = 0;
      end
    end
    repeat (2) @(posedge clk);
    #1;
    rst4 = 1;
    repeat (8) begin
      @(posedge clk);
      #1;
      chk("l4_no_ready", 32'(c4_ready), 0);
      chk("l4_stay_idle", 32'(busy4), 0);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Two-master arbiter and sequencer for the core's single-port unified memory. It shares the memory between the multicycle core, which issues both instruction fetch and load/store, and an external master such as the program loader or debug port. It grants one transaction at a time, round-robin, and sequences the memory address, write and read-latency phases for that transaction. It returns a one-cycle ready pulse to the granted master.

## Interface
- ADDR_W, 32, address width for both masters and the memory.
- DATA_W, 32, data width.
- READ_LAT, 2, memory read latency in cycles, counting the address cycle; legal range 1..7. A value of 1 means asynchronous read; 2 means synchronous BRAM.

Ports:
- clk  in  1  clock; everything is rising-edge.
- rst  in  1  asynchronous, active-low reset.
- core_req  in  1  core transaction request.
- core_we  in  1  1 = write, 0 = read.
- core_addr  in  ADDR_W  core address.
- core_wdata  in  DATA_W  core write data.
- core_ready  out  1  one-cycle completion pulse to the core.
- ext_req, ext_we, ext_addr, ext_wdata, ext_ready: the same signals for the external master.
- rdata  out  DATA_W  read data, shared by both masters; valid while the owner's ready is high, and held until the next read completes.
- owner  out  1  0 = core, 1 = external; the master of the current or most recent transaction.
- busy  out  1  high in every state except IDLE.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  DATA_W  memory read data.

## Operation
- States: IDLE, ACCESS, RESP.
- Reset (asynchronous, takes effect immediately):
  - state = IDLE.
  - mem_we, core_ready, ext_ready, busy = 0.
  - mem_addr, mem_wdata, rdata = 0.
  - owner = 1, so that the first tie after reset goes to the core.
  - Latency counter = 0.
- Arbitration in IDLE:
  - Only one req high: grant that master.
  - Both high: grant the master that is not the current owner (round-robin).
  - No req: remain in IDLE; all memory outputs hold their values; mem_we = 0.
- On grant, registered at the edge leaving IDLE:
  - owner updated.
  - mem_addr and mem_wdata latched from the granted master.
  - A we flag latched.
  - Counter loaded with READ_LAT-1 for a read, 0 for a write.
  - The master's addr, wdata and we are ignored after this edge until its ready.
- ACCESS:
  - Write: mem_we = 1 for exactly one cycle, then go to RESP.
  - Read: mem_we = 0 and mem_addr is held. The counter decrements each cycle. When it reaches 0, rdata is loaded from mem_rdata at that edge and the state goes to RESP.
- RESP:
  - Owner's ready = 1 for exactly one cycle; the other master's ready = 0.
  - Then go to IDLE unconditionally.
- Master rule: a master holds req, addr, wdata and we stable from assertion until the edge on which it samples its ready high. A req still high in the following IDLE cycle is a new transaction.
- Losing master: its req stays pending with no side effects. It is served on the next IDLE, and round-robin guarantees this.
- Writes never modify rdata.
- Reset during ACCESS or RESP:
  - The transaction is abandoned; no ready pulse is issued.
  - mem_we drops asynchronously.
  - A partially issued write may or may not have landed in memory; the masters must reissue it.

## Timing
- Request is high in IDLE cycle 0:
  - Write: ACCESS in cycle 1 with mem_we = 1; ready in cycle 2.
  - Read: ACCESS in cycles 1..READ_LAT; ready and valid rdata in cycle READ_LAT+1.
- mem_rdata must be valid during the last ACCESS cycle, i.e. READ_LAT-1 cycles after mem_addr first changes.
- Minimum occupancy per transaction: write 3 cycles (IDLE, ACCESS, RESP); read READ_LAT+2 cycles.
- Both masters requesting continuously: grants alternate. Each master waits at most one other transaction before its own.
- No combinational path from any req input to any output. All outputs are registered or decoded from state.

## Test plan
- Reset: hold rst = 0 with both reqs high. Required: mem_we = 0, both readys = 0, busy = 0, owner = 1. After release, the first grant goes to the core.
- Core read, READ_LAT = 2: core_addr = 0x40, memory returns 0xDEADBEEF. Required: mem_addr = 0x40 in cycles 1-2; core_ready high in cycle 3 only; rdata = 0xDEADBEEF; ext_ready never high.
- External write: ext_addr = 0x100, ext_wdata = 0x12345678. Required: exactly one mem_we pulse in cycle 1 carrying those values; ext_ready high in cycle 2; rdata unchanged.
- Simultaneous requests: both reqs held high for 4 transactions. Required: owner sequence is core, ext, core, ext, and the ready pulses alternate to match.
- Reset mid-read: READ_LAT = 4, assert rst in the second ACCESS cycle. Required: immediately state = IDLE, busy = 0, no ready pulse ever issued, rdata = 0.
- Stability: change core_addr during ACCESS. Required: mem_addr keeps the value latched at grant.
